// File: rtl/ram_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single-port RAM with
// fixed read latency; one transaction at a time through IDLE/ISSUE/WAIT/RESP.
module ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata valid and holds req
  // until its one-cycle done; the command is captured on the granting edge,
  // so later changes to we/addr/wdata do not affect the transaction.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic       gnt_dma;
  logic       last_dma;
  logic       lat_we;
  logic [2:0] cnt;
  logic       pick_dma;

  // DMA wins when alone, or on a tie when the CPU was served last.
  always_comb begin
    pick_dma = dma_req && (!cpu_req || !last_dma);
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      gnt_dma   <= 1'b0;
      last_dma  <= 1'b1;
      lat_we    <= 1'b0;
      cnt       <= 3'd0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            gnt_dma  <= pick_dma;
            last_dma <= pick_dma;
            lat_we   <= pick_dma ? dma_we : cpu_we;
            ram_addr <= pick_dma ? dma_addr : cpu_addr;
            ram_data <= pick_dma ? dma_wdata : cpu_wdata;
            ram_wren <= pick_dma ? dma_we : cpu_we;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt      <= 3'(RD_LAT);
          ram_wren <= 1'b0;
          ram_data <= '0;
          if (lat_we) begin
            ram_addr <= '0;
            cpu_done <= !gnt_dma;
            dma_done <= gnt_dma;
            state    <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // Final wait edge: ram_q is valid now for the address issued earlier.
          if (cnt == 3'd1) begin
            if (gnt_dma) dma_rdata <= ram_q;
            else         cpu_rdata <= ram_q;
            ram_addr <= '0;
            cpu_done <= !gnt_dma;
            dma_done <= gnt_dma;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM of read latency RL;
// each task drives one scenario and compares outputs cycle by cycle.
module tb_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          Clock;
  logic          Reset;
  logic          cpu_req, cpu_we, cpu_done;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_done;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          busy, ram_wren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .dbg_state(dbg_state)
  );

  // Clock and RAM model: read data appears RL cycles after the address.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:RL-1];
  always @(posedge Clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[RL-1];

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    checks++; if ({cpu_done, dma_done, ram_wren} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {cpu_done, dma_done, ram_wren}); end
    checks++; if (ram_addr !== '0 || ram_data !== '0) begin errors++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", ram_addr, ram_data); end
    checks++; if (cpu_rdata !== '0 || dma_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dma_rdata); end
    Reset = 1'b0;
  endtask

  task automatic test_cpu_write;
    int wren_cnt = 0;
    cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (ram_wren) wren_cnt++;
      if (c == 1) begin
        checks++; if (ram_wren !== 1'b1 || ram_addr !== 9'h005 || ram_data !== 32'hDEADBEEF) begin
          errors++; $display("FAIL cpu_wr_issue: got wren=%0b addr=%h data=%h want 1/005/deadbeef", ram_wren, ram_addr, ram_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cpu_wr_busy: got %0b want 1", busy); end
      end
      checks++; if (cpu_done !== (c == 2)) begin errors++; $display("FAIL cpu_wr_done c%0d: got %0b want %0b", c, cpu_done, (c == 2)); end
      checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL cpu_wr_dma_done c%0d: got %0b want 0", c, dma_done); end
      if (c == 3) cpu_req = 1'b0;
      if (c == 4) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cpu_wr_idle: got busy %0b want 0", busy); end
      end
    end
    checks++; if (wren_cnt != 1) begin errors++; $display("FAIL cpu_wr_wren_width: got %0d want 1", wren_cnt); end
  endtask

  task automatic test_dma_read;
    dma_we = 1'b0; dma_addr = 9'h005; dma_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (dma_done !== (c == 4)) begin errors++; $display("FAIL dma_rd_done c%0d: got %0b want %0b", c, dma_done, (c == 4)); end
      checks++; if (cpu_done !== 1'b0 || ram_wren !== 1'b0) begin errors++; $display("FAIL dma_rd_quiet c%0d: got cpu_done=%0b wren=%0b want 0/0", c, cpu_done, ram_wren); end
      if (c <= 3) begin
        checks++; if (ram_addr !== 9'h005) begin errors++; $display("FAIL dma_rd_addr c%0d: got %h want 005", c, ram_addr); end
      end
      if (c == 5) begin
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL dma_rd_addr_idle: got %h want 0", ram_addr); end
        dma_req = 1'b0;
      end
    end
    checks++; if (dma_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dma_rd_data: got %h want deadbeef", dma_rdata); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL dma_rd_cpu_rdata: got %h want 0", cpu_rdata); end
  endtask

  task automatic test_round_robin;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    logic       prev_cpu = 1'b0;
    logic       prev_dma = 1'b0;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'hAAAA0001; cpu_req = 1'b1;
    dma_we = 1'b1; dma_addr = 9'h021; dma_wdata = 32'hBBBB0002; dma_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++; if (cpu_done && dma_done) begin errors++; $display("FAIL rr_coincident c%0d: got both done want at most one", c); end
      checks++; if ((cpu_done && prev_cpu) || (dma_done && prev_dma)) begin errors++; $display("FAIL rr_width c%0d: got done wider than 1 cycle want 1", c); end
      if (cpu_done) got_q.push_back(1'b0);
      if (dma_done) got_q.push_back(1'b1);
      prev_cpu = cpu_done;
      prev_dma = dma_done;
      if (c == 12) begin cpu_req = 1'b0; dma_req = 1'b0; end
    end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rr_count: got %0d grants want 4", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rr_order: got %0d want %0d (0=cpu 1=dma)", got_q[0], exp_q[0]); end
      void'(got_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_read_then_dma;
    cpu_we = 1'b0; cpu_addr = 9'h020; cpu_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++; if (cpu_done !== (c == 4)) begin errors++; $display("FAIL rd_dma_cpu_done c%0d: got %0b want %0b", c, cpu_done, (c == 4)); end
      checks++; if (dma_done !== (c == 7)) begin errors++; $display("FAIL rd_dma_dma_done c%0d: got %0b want %0b", c, dma_done, (c == 7)); end
      if (c == 2) begin
        dma_we = 1'b1; dma_addr = 9'h030; dma_wdata = 32'hC0C0C0C0; dma_req = 1'b1;
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_dma_idle: got busy %0b want 0", busy); end
        cpu_req = 1'b0;
      end
      if (c == 6) begin
        checks++; if (ram_wren !== 1'b1 || ram_addr !== 9'h030 || ram_data !== 32'hC0C0C0C0) begin
          errors++; $display("FAIL rd_dma_issue: got wren=%0b addr=%h data=%h want 1/030/c0c0c0c0", ram_wren, ram_addr, ram_data); end
      end
      if (c == 8) dma_req = 1'b0;
    end
    checks++; if (cpu_rdata !== 32'hAAAA0001) begin errors++; $display("FAIL rd_dma_cpu_rdata: got %h want aaaa0001", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL rd_dma_dma_rdata: got %h want 0", dma_rdata); end
  endtask

  task automatic test_addr_change;
    cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 32'h11111111; cpu_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (ram_addr !== 9'h010 || ram_data !== 32'h11111111 || ram_wren !== 1'b1) begin
          errors++; $display("FAIL addr_chg_issue: got addr=%h data=%h wren=%0b want 010/11111111/1", ram_addr, ram_data, ram_wren); end
        cpu_addr = 9'h1FF; cpu_wdata = 32'h22222222; cpu_we = 1'b0;
      end
      checks++; if (cpu_done !== (c == 2)) begin errors++; $display("FAIL addr_chg_done c%0d: got %0b want %0b", c, cpu_done, (c == 2)); end
      if (c == 3) cpu_req = 1'b0;
    end
    dma_we = 1'b0; dma_addr = 9'h010; dma_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (dma_done !== (c == 4)) begin errors++; $display("FAIL addr_chg_rd_done c%0d: got %0b want %0b", c, dma_done, (c == 4)); end
      if (c == 5) dma_req = 1'b0;
    end
    checks++; if (dma_rdata !== 32'h11111111) begin errors++; $display("FAIL addr_chg_readback: got %h want 11111111", dma_rdata); end
  endtask

  task automatic test_reset_in_issue;
    dma_we = 1'b1; dma_addr = 9'h040; dma_wdata = 32'h00000055; dma_req = 1'b1;
    tick();
    checks++; if (ram_wren !== 1'b1 || dbg_state !== 2'd1) begin errors++; $display("FAIL rst_issue_pre: got wren=%0b state=%0d want 1/1", ram_wren, dbg_state); end
    Reset = 1'b1;
    tick();
    checks++; if (ram_wren !== 1'b0 || busy !== 1'b0 || ram_addr !== '0) begin
      errors++; $display("FAIL rst_issue_post: got wren=%0b busy=%0b addr=%h want 0/0/0", ram_wren, busy, ram_addr); end
    Reset = 1'b0;
    dma_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL rst_issue_no_done c%0d: got %0b want 0", c, dma_done); end
      tick();
    end
    cpu_we = 1'b1; cpu_addr = 9'h041; cpu_wdata = 32'h41; cpu_req = 1'b1;
    dma_we = 1'b1; dma_addr = 9'h042; dma_wdata = 32'h42; dma_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++; if (cpu_done !== (c == 2)) begin errors++; $display("FAIL rst_tie_cpu_done c%0d: got %0b want %0b", c, cpu_done, (c == 2)); end
      checks++; if (dma_done !== (c == 5)) begin errors++; $display("FAIL rst_tie_dma_done c%0d: got %0b want %0b", c, dma_done, (c == 5)); end
      if (c == 3) cpu_req = 1'b0;
      if (c == 6) dma_req = 1'b0;
    end
  endtask

  initial begin
    Reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_round_robin();
    test_read_then_dma();
    test_addr_change();
    test_reset_in_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
